// File: rtl/vga_timing.sv
// vga_timing: raster timing generator for the VGA output path.
// Counts pixel clocks into a horizontal/vertical position. It drives sync,
// active-video and line/frame pulses aligned with that position, plus a
// "fetch" view that runs one cycle ahead for consumers with a 1-cycle lookup.
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-high
//   Hsync/Vsync  sync outputs, asserted level = SYNC_POL
//   active       current position is inside the visible area
//   pixel_x/y    current raster position
//   fetch_valid  next cycle's position is visible
//   fetch_x/y    next cycle's raster position
//   line_start   pulse at pixel_x == 0
//   frame_start  pulse at pixel_x == 0 and pixel_y == 0
//   frame_count  frames started since reset, free-running 8-bit
module vga_timing #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       Hsync,
    output logic       Vsync,
    output logic       active,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       fetch_valid,
    output logic [9:0] fetch_x,
    output logic [9:0] fetch_y,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned CW      = 10;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS     = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS     = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CW-1:0] next_x;
    logic [CW-1:0] next_y;
    logic [CW-1:0] after_x;
    logic [CW-1:0] after_y;
    logic          next_active;
    logic          after_active;
    logic          next_hs;
    logic          next_vs;
    logic          next_line;
    logic          next_frame;

    // Position one edge ahead (what pixel_* become) and two edges ahead
    // (what fetch_* become), both with line and frame wrap.
    always_comb begin
        next_x       = pixel_x + CW'(1);
        next_y       = pixel_y;
        if (pixel_x == H_LAST) begin
            next_x = '0;
            next_y = (pixel_y == V_LAST) ? '0 : pixel_y + CW'(1);
        end

        after_x      = next_x + CW'(1);
        after_y      = next_y;
        if (next_x == H_LAST) begin
            after_x = '0;
            after_y = (next_y == V_LAST) ? '0 : next_y + CW'(1);
        end

        next_active  = (next_x < H_VIS) && (next_y < V_VIS);
        after_active = (after_x < H_VIS) && (after_y < V_VIS);
        next_hs      = (next_x >= HS_FIRST) && (next_x <= HS_LAST);
        next_vs      = (next_y >= VS_FIRST) && (next_y <= VS_LAST);
        next_line    = (next_x == '0);
        next_frame   = next_line && (next_y == '0);
    end

    // Reset parks the raster on the last position so the first edge after
    // release lands on (0,0) with a frame_start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_x     <= H_LAST;
            pixel_y     <= V_LAST;
            fetch_x     <= '0;
            fetch_y     <= '0;
            fetch_valid <= 1'b1;
            active      <= 1'b0;
            Hsync       <= ~SYNC_POL;
            Vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            pixel_x     <= next_x;
            pixel_y     <= next_y;
            fetch_x     <= after_x;
            fetch_y     <= after_y;
            fetch_valid <= after_active;
            active      <= next_active;
            Hsync       <= next_hs ? SYNC_POL : ~SYNC_POL;
            Vsync       <= next_vs ? SYNC_POL : ~SYNC_POL;
            line_start  <= next_line;
            frame_start <= next_frame;
            if (next_frame) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed bench for vga_timing using a reduced raster
// (16x11 total, 8x6 visible) so full frames and the frame_count wrap are short.
// Horizontal: visible 0..7, FP 8..9, sync 10..12, BP 13..15.
// Vertical:   visible 0..5, FP 6, sync 7..8, BP 9..10.
module tb_vga_timing;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       reset;
    logic       Hsync, Vsync, active, fetch_valid, line_start, frame_start;
    logic [9:0] pixel_x, pixel_y, fetch_x, fetch_y;
    logic [7:0] frame_count;

    int checks = 0;
    int errors = 0;

    vga_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .Hsync(Hsync), .Vsync(Vsync),
        .active(active), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .fetch_valid(fetch_valid), .fetch_x(fetch_x), .fetch_y(fetch_y),
        .line_start(line_start), .frame_start(frame_start),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int x, y, hs, vs, act, ls, fs, fx, fy, fv, fc;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input int act_v, input int exp_v);
        checks++;
        if (act_v != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input int x, input int y,
                             input int hs, input int vs, input int act,
                             input int ls, input int fs, input int fx,
                             input int fy, input int fv, input int fc);
        chk({tag, " pixel_x"},     int'(pixel_x),     x);
        chk({tag, " pixel_y"},     int'(pixel_y),     y);
        chk({tag, " Hsync"},       int'(Hsync),       hs);
        chk({tag, " Vsync"},       int'(Vsync),       vs);
        chk({tag, " active"},      int'(active),      act);
        chk({tag, " line_start"},  int'(line_start),  ls);
        chk({tag, " frame_start"}, int'(frame_start), fs);
        chk({tag, " fetch_x"},     int'(fetch_x),     fx);
        chk({tag, " fetch_y"},     int'(fetch_y),     fy);
        chk({tag, " fetch_valid"}, int'(fetch_valid), fv);
        chk({tag, " frame_count"}, int'(frame_count), fc);
    endtask

    // Advance k rising edges, then settle on the falling edge for sampling.
    task automatic step(input int k);
        for (int i = 0; i < k; i++) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check_all(tag, HT - 1, VT - 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        int cur;
        int mx, my, mfc, nx, ny;
        //          n   x  y  hs vs act ls fs fx fy fv fc
        tbl[0]  = '{  1,  0, 0, 1, 1, 1, 1, 1,  1, 0, 1, 1};
        tbl[1]  = '{  2,  1, 0, 1, 1, 1, 0, 0,  2, 0, 1, 1};
        tbl[2]  = '{  8,  7, 0, 1, 1, 1, 0, 0,  8, 0, 0, 1};
        tbl[3]  = '{  9,  8, 0, 1, 1, 0, 0, 0,  9, 0, 0, 1};
        tbl[4]  = '{ 10,  9, 0, 1, 1, 0, 0, 0, 10, 0, 0, 1};
        tbl[5]  = '{ 11, 10, 0, 0, 1, 0, 0, 0, 11, 0, 0, 1};
        tbl[6]  = '{ 13, 12, 0, 0, 1, 0, 0, 0, 13, 0, 0, 1};
        tbl[7]  = '{ 14, 13, 0, 1, 1, 0, 0, 0, 14, 0, 0, 1};
        tbl[8]  = '{ 16, 15, 0, 1, 1, 0, 0, 0,  0, 1, 1, 1};
        tbl[9]  = '{ 17,  0, 1, 1, 1, 1, 1, 0,  1, 1, 1, 1};
        tbl[10] = '{ 96, 15, 5, 1, 1, 0, 0, 0,  0, 6, 0, 1};
        tbl[11] = '{ 97,  0, 6, 1, 1, 0, 1, 0,  1, 6, 0, 1};
        tbl[12] = '{112, 15, 6, 1, 1, 0, 0, 0,  0, 7, 0, 1};
        tbl[13] = '{113,  0, 7, 1, 0, 0, 1, 0,  1, 7, 0, 1};
        tbl[14] = '{144, 15, 8, 1, 0, 0, 0, 0,  0, 9, 0, 1};
        tbl[15] = '{145,  0, 9, 1, 1, 0, 1, 0,  1, 9, 0, 1};
        tbl[16] = '{176, 15,10, 1, 1, 0, 0, 0,  0, 0, 1, 1};
        tbl[17] = '{177,  0, 0, 1, 1, 1, 1, 1,  1, 0, 1, 2};

        // Reset held across several edges.
        reset = 1'b1;
        step(3);
        check_reset("reset");

        // Release between edges; table counts edges since release.
        reset = 1'b0;
        cur = 0;
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].n - cur);
            cur = tbl[i].n;
            check_all($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].hs,
                      tbl[i].vs, tbl[i].act, tbl[i].ls, tbl[i].fs, tbl[i].fx,
                      tbl[i].fy, tbl[i].fv, tbl[i].fc);
        end

        // Two frames cycle by cycle against a small position model.
        mx = 0; my = 0; mfc = 2;
        for (int c = 0; c < 2 * FRAME; c++) begin
            step(1);
            mx = mx + 1;
            if (mx == HT) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end
            if (mx == 0 && my == 0) mfc++;
            nx = mx + 1;
            ny = my;
            if (nx == HT) begin
                nx = 0;
                ny = (my == VT - 1) ? 0 : my + 1;
            end
            check_all($sformatf("run(%0d,%0d)", mx, my), mx, my,
                      (mx >= HA + HF && mx <= HA + HF + HS - 1) ? 0 : 1,
                      (my >= VA + VF && my <= VA + VF + VS - 1) ? 0 : 1,
                      (mx < HA && my < VA) ? 1 : 0,
                      (mx == 0) ? 1 : 0,
                      (mx == 0 && my == 0) ? 1 : 0,
                      nx, ny, (nx < HA && ny < VA) ? 1 : 0, mfc % 256);
        end

        // frame_count wrap: now at (0,0) with count 4.
        step(251 * FRAME);
        check_all("fc255", 0, 0, 1, 1, 1, 1, 1, 1, 0, 1, 255);
        step(FRAME);
        check_all("fc_wrap", 0, 0, 1, 1, 1, 1, 1, 1, 0, 1, 0);

        // Asynchronous reset mid-frame at (3,2), applied between edges.
        step(2 * HT + 3);
        chk("pre_rst pixel_x", int'(pixel_x), 3);
        chk("pre_rst pixel_y", int'(pixel_y), 2);
        chk("pre_rst active",  int'(active),  1);
        #1 reset = 1'b1;
        #1 check_reset("async_rst");
        step(2);
        check_reset("rst_hold");
        reset = 1'b0;
        step(1);
        check_all("restart", 0, 0, 1, 1, 1, 1, 1, 1, 0, 1, 1);
        step(1);
        check_all("restart2", 1, 0, 1, 1, 1, 0, 0, 2, 0, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
